// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding and default command codes for the SPI frame receiver
package spi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam logic [7:0] CMD_WR_DEFAULT = 8'hFF;
  localparam logic [7:0] CMD_RD_DEFAULT = 8'h0F;

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - parametrised LSB-first shift register with parallel load
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] ld_data_i,
  input  logic         sh_i,
  input  logic         sh_in_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // New bits enter at the MSB so the first bit shifted in ends up at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (ld_i) begin
      q_q <= ld_data_i;
    end else if (sh_i) begin
      q_q <= {sh_in_i, q_q[W-1:1]};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SPI frame receiver: data/address/command decode with miso read-back
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int               ADDR_W = 24,
  parameter int               DATA_W = 32,
  parameter int               CMD_W  = 8,
  parameter logic [CMD_W-1:0] CMD_WR = CMD_W'(CMD_WR_DEFAULT),
  parameter logic [CMD_W-1:0] CMD_RD = CMD_W'(CMD_RD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] address_out,
  output logic [DATA_W-1:0] data_out,
  output logic              wr_en_out,
  output logic              rd_en_out,
  input  logic [DATA_W-1:0] rd_data_in,
  input  logic              rd_valid_in,
  output logic              cmd_err_out,
  output logic              abort_out
);

  localparam int FRAME_W = DATA_W + ADDR_W + CMD_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               armed_q;
  logic               done_q;
  logic [DATA_W-1:0]  rd_hold_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               wr_en_q, rd_en_q, cmd_err_q, abort_q;

  logic [FRAME_W-1:0] frame_w;
  logic [DATA_W-1:0]  miso_sr_w;
  logic [CMD_W-1:0]   cmd_w;
  logic               start, in_shift, sample, last_bit, miso_sh;

  // armed_q blocks a frame start until CS has been seen low after reset.
  assign start    = (state_q == ST_IDLE) && CS && armed_q;
  assign in_shift = (state_q == ST_SHIFT) && CS;
  assign sample   = start || in_shift;
  assign last_bit = in_shift && (cnt_q == CNT_W'(FRAME_W - 1));
  assign miso_sh  = in_shift && (cnt_q < CNT_W'(DATA_W));
  assign cmd_w    = frame_w[FRAME_W-1 -: CMD_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = ST_SHIFT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (!CS) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_bit) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!CS) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
      rd_hold_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cmd_err_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_q | ~CS;
      done_q    <= last_bit;
      wr_en_q   <= done_q && (cmd_w == CMD_WR);
      rd_en_q   <= done_q && (cmd_w == CMD_RD);
      cmd_err_q <= done_q && (cmd_w != CMD_WR) && (cmd_w != CMD_RD);
      abort_q   <= (state_q == ST_SHIFT) && !CS;
      if (done_q && ((cmd_w == CMD_WR) || (cmd_w == CMD_RD))) begin
        addr_q <= frame_w[DATA_W +: ADDR_W];
      end
      if (done_q && (cmd_w == CMD_WR)) begin
        data_q <= frame_w[DATA_W-1:0];
      end
      if (rd_valid_in && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
        rd_hold_q <= rd_data_in;
      end
    end
  end

  spi_shift_reg #(.W(FRAME_W)) u_frame_sr (
    .clk       (clk),
    .rst       (rst),
    .ld_i      (1'b0),
    .ld_data_i ('0),
    .sh_i      (sample),
    .sh_in_i   (mosi),
    .q_o       (frame_w)
  );

  // The miso shifter works on a copy so an aborted frame cannot disturb the held read data.
  spi_shift_reg #(.W(DATA_W)) u_miso_sr (
    .clk       (clk),
    .rst       (rst),
    .ld_i      (start),
    .ld_data_i (rd_hold_q >> 1),
    .sh_i      (miso_sh),
    .sh_in_i   (1'b0),
    .q_o       (miso_sr_w)
  );

  assign miso        = (start & rd_hold_q[0]) | (miso_sh & miso_sr_w[0]);
  assign address_out = addr_q;
  assign data_out    = data_q;
  assign wr_en_out   = wr_en_q;
  assign rd_en_out   = rd_en_q;
  assign cmd_err_out = cmd_err_q;
  assign abort_out   = abort_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - self-checking bench for spi_frame_rx with a frame-level reference model
module tb_spi_frame_rx;

  logic        clk;
  logic        rst;
  logic        CS;
  logic        mosi;
  logic        miso;
  logic [23:0] address_out;
  logic [31:0] data_out;
  logic        wr_en_out;
  logic        rd_en_out;
  logic [31:0] rd_data_in;
  logic        rd_valid_in;
  logic        cmd_err_out;
  logic        abort_out;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0, rd_seen = 0, err_seen = 0, abort_seen = 0;

  logic [23:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic [31:0] exp_rbuf = '0;

  spi_frame_rx dut (
    .clk         (clk),
    .rst         (rst),
    .CS          (CS),
    .mosi        (mosi),
    .miso        (miso),
    .address_out (address_out),
    .data_out    (data_out),
    .wr_en_out   (wr_en_out),
    .rd_en_out   (rd_en_out),
    .rd_data_in  (rd_data_in),
    .rd_valid_in (rd_valid_in),
    .cmd_err_out (cmd_err_out),
    .abort_out   (abort_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe cycles are counted 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (wr_en_out)   wr_seen++;
    if (rd_en_out)   rd_seen++;
    if (cmd_err_out) err_seen++;
    if (abort_out)   abort_seen++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_idle(input logic [31:0] w);
    @(negedge clk);
    rd_valid_in = 1'b1;
    rd_data_in  = w;
    @(negedge clk);
    rd_valid_in = 1'b0;
    exp_rbuf    = w;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [23:0] addr,
                           input logic [31:0] data, input int nbits, input int rst_at,
                           input bit rd_done_req, input logic [31:0] rd_word, input bit rd_mid);
    logic [127:0] bits;
    logic [31:0]  miso_obs, mask, old_rbuf;
    bit           hi_seen, rd_done;
    int           w0, r0, e0, a0, ew, er, ee, ea;
    bits     = {$urandom(), $urandom(), cmd, addr, data};
    rd_done  = rd_done_req && (nbits >= 64) && (rst_at < 0);
    old_rbuf = exp_rbuf;
    miso_obs = '0;
    hi_seen  = 1'b0;
    w0 = wr_seen; r0 = rd_seen; e0 = err_seen; a0 = abort_seen;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      CS          = 1'b1;
      mosi        = bits[i];
      rst         = (rst_at >= 0) && (i == rst_at);
      rd_valid_in = rd_mid && (i == 10);
      if (rd_mid && (i == 10)) rd_data_in = $urandom();
      #1;
      if (i < 32) miso_obs[i] = miso;
      else if (miso !== 1'b0) hi_seen = 1'b1;
    end
    @(negedge clk);
    rst         = 1'b0;
    rd_valid_in = 1'b0;
    if (rd_done) begin
      rd_valid_in = 1'b1;
      rd_data_in  = rd_word;
      @(negedge clk);
      rd_valid_in = 1'b0;
    end
    CS   = 1'b0;
    mosi = 1'b0;
    repeat (3) @(negedge clk);

    ew = 0; er = 0; ee = 0; ea = 0;
    if (rst_at >= 0) begin
      exp_addr = '0;
      exp_data = '0;
      exp_rbuf = '0;
    end else if (nbits >= 64) begin
      if (cmd == 8'hFF) begin
        ew = 1; exp_addr = addr; exp_data = data;
      end else if (cmd == 8'h0F) begin
        er = 1; exp_addr = addr;
      end else begin
        ee = 1;
      end
      if (rd_done) exp_rbuf = rd_word;
    end else begin
      ea = 1;
    end

    check({tag, ".wr"},    64'(wr_seen - w0),    64'(ew));
    check({tag, ".rd"},    64'(rd_seen - r0),    64'(er));
    check({tag, ".err"},   64'(err_seen - e0),   64'(ee));
    check({tag, ".abort"}, 64'(abort_seen - a0), 64'(ea));
    check({tag, ".addr"},  64'(address_out),     64'(exp_addr));
    check({tag, ".data"},  64'(data_out),        64'(exp_data));
    if (rst_at < 0) begin
      mask = (nbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
      check({tag, ".miso"},    64'(miso_obs & mask), 64'(old_rbuf & mask));
      check({tag, ".miso_hi"}, 64'(hi_seen),         64'(0));
    end
  endtask

  initial begin
    logic [7:0] cmd;
    int         nb, sel;
    bit         rdd, rdm;
    rst = 1'b1; CS = 1'b0; mosi = 1'b0; rd_data_in = '0; rd_valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.addr",  64'(address_out), 64'(0));
    check("rst.data",  64'(data_out),    64'(0));
    check("rst.wr",    64'(wr_en_out),   64'(0));
    check("rst.rd",    64'(rd_en_out),   64'(0));
    check("rst.err",   64'(cmd_err_out), 64'(0));
    check("rst.abort", 64'(abort_out),   64'(0));
    check("rst.miso",  64'(miso),        64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame("write",    8'hFF, 24'h000ABC, 32'hA5A51234, 64, -1, 1'b0, '0, 1'b0);
    run_frame("read",     8'h0F, 24'h000010, $urandom(),   64, -1, 1'b1, 32'hDEADBEEF, 1'b0);
    run_frame("abort40",  8'hFF, 24'h123456, $urandom(),   40, -1, 1'b0, '0, 1'b0);
    run_frame("post_abt", 8'hFF, 24'h00CAFE, 32'h0BADF00D, 64, -1, 1'b0, '0, 1'b0);
    run_frame("badcmd",   8'h3C, 24'h777777, 32'h11112222, 64, -1, 1'b0, '0, 1'b0);
    run_frame("over70",   8'hFF, 24'h0F0F0F, 32'h89ABCDEF, 70, -1, 1'b0, '0, 1'b0);
    load_idle(32'h5A5AC3C3);
    run_frame("rd_mid",   8'h0F, 24'h000321, $urandom(),   64, -1, 1'b0, '0, 1'b1);
    run_frame("rst30",    8'hFF, 24'h0ABCDE, 32'h12345678, 64, 30, 1'b0, '0, 1'b0);
    run_frame("post_rst", 8'hFF, 24'h000042, 32'hFEEDFACE, 64, -1, 1'b0, '0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      sel = int'($urandom_range(0, 3));
      cmd = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h0F : (sel == 2) ? 8'($urandom()) : 8'hFF;
      sel = int'($urandom_range(0, 3));
      nb  = (sel == 0) ? int'($urandom_range(1, 63)) :
            (sel == 1) ? int'($urandom_range(65, 100)) : 64;
      rdd = bit'($urandom_range(0, 1));
      rdm = (nb > 11) && bit'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) load_idle($urandom());
      run_frame($sformatf("rand%0d", k), cmd, 24'($urandom()), $urandom(), nb, -1, rdd,
                $urandom(), rdm);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
